mul_ucode_seq: RTL and testbench

- Microcode sequencer directly downstream of the fetch/filter stage.
- Consumes the multiply opcode, operand fields, ucode_flag and ghost_PC that fetch produces. Returns ghost_instruction and ucode_done to fetch.
- Expands immediate multiply / multiply-accumulate into shift-add micro-ops, one per cycle. Only set bits of the immediate generate work.

---
 rtl/mul_ucode_seq_if.sv | 22 ++
 rtl/mul_ucode_seq.sv | 191 +++++++++++++++++++
 tb/tb_mul_ucode_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mul_ucode_seq_if.sv
// Fetch <-> microcode sequencer link: multiply operands in, micro-op stream and status out.
interface mul_ucode_seq_if;
   logic        ucode_flag;
   logic [6:0]  mul_opcode;
   logic [3:0]  mul_imm_rd;
   logic [3:0]  mul_imm_rs;
   logic [15:0] mul_imm_imm;
   logic [3:0]  ghost_PC;
   logic [31:0] ghost_instruction;
   logic        ucode_done;
   logic        seq_err;

   modport master (
      output ucode_flag, mul_opcode, mul_imm_rd, mul_imm_rs, mul_imm_imm, ghost_PC,
      input  ghost_instruction, ucode_done, seq_err
   );

   modport slave (
      input  ucode_flag, mul_opcode, mul_imm_rd, mul_imm_rs, mul_imm_imm, ghost_PC,
      output ghost_instruction, ucode_done, seq_err
   );
endinterface

// File: rtl/mul_ucode_seq.sv
// Expands immediate multiply / multiply-accumulate into shift-add micro-ops,
// one per cycle, visiting only the set bits of the immediate.
module mul_ucode_seq (
   input  logic           clk,
   input  logic           rst,
   mul_ucode_seq_if.slave bus
);
   localparam int unsigned OP_W   = 7;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned IMM_W  = 16;
   localparam int unsigned STEP_W = 6;
   localparam int unsigned UOP_W  = 32;

   localparam logic [OP_W-1:0] OP_NOP  = 7'b1100100;
   localparam logic [OP_W-1:0] OP_MOV  = 7'b0000001;
   localparam logic [OP_W-1:0] OP_MOVI = 7'b0000010;
   localparam logic [OP_W-1:0] OP_ADD  = 7'b0000100;
   localparam logic [OP_W-1:0] OP_LSL  = 7'b0000110;
   localparam logic [OP_W-1:0] OP_CMPI = 7'b0001010;

   localparam logic [OP_W-1:0] OPC_MULI   = 7'b0010000;
   localparam logic [OP_W-1:0] OPC_MULI_S = 7'b0011000;
   localparam logic [OP_W-1:0] OPC_MLAI   = 7'b0110000;
   localparam logic [OP_W-1:0] OPC_MLAI_S = 7'b0111000;

   localparam logic [REG_W-1:0] SCRATCH  = 4'd15;
   localparam logic [UOP_W-1:0] NOP_WORD = {OP_NOP, 25'd0};

   typedef enum logic [2:0] {
      P_COPY  = 3'd0,
      P_CLEAR = 3'd1,
      P_SHIFT = 3'd2,
      P_ADD   = 3'd3,
      P_FLAGS = 3'd4
   } phase_t;

   phase_t             phase, phase_nxt, phase_after;
   logic [REG_W-1:0]   pos, pos_nxt, pos_after;
   logic [REG_W-1:0]   cap_rd, cap_rd_nxt;
   logic [REG_W-1:0]   cap_rs, cap_rs_nxt;
   logic [STEP_W-1:0]  step, step_nxt;
   logic [IMM_W-1:0]   mask, mask_nxt, mask_after;
   logic               err, err_nxt;
   logic               resolve, last_op;
   logic               op_valid, is_acc, is_s;
   logic [4:0]         nb_cur, nb_after;
   logic [UOP_W-1:0]   instr;
   logic               done;

   // {found, index} of the lowest set bit
   function automatic logic [4:0] lowest_set(input logic [IMM_W-1:0] m);
      logic [4:0] r;
      r = '0;
      for (int i = IMM_W - 1; i >= 0; i--) begin
         if (m[i]) r = {1'b1, 4'(i)};
      end
      return r;
   endfunction

   function automatic logic [UOP_W-1:0] uop(input logic [OP_W-1:0]  op,
                                            input logic [REG_W-1:0] rd,
                                            input logic [REG_W-1:0] rs,
                                            input logic [IMM_W-1:0] imm);
      return {op, rd, rs, 1'b0, imm};
   endfunction

   assign op_valid = (bus.mul_opcode == OPC_MULI)   || (bus.mul_opcode == OPC_MULI_S) ||
                     (bus.mul_opcode == OPC_MLAI)   || (bus.mul_opcode == OPC_MLAI_S);
   assign is_acc   = bus.mul_opcode[5];
   assign is_s     = bus.mul_opcode[3];
   assign nb_cur   = lowest_set(mask);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         phase  <= P_COPY;
         pos    <= '0;
         step   <= '0;
         mask   <= '0;
         cap_rd <= '0;
         cap_rs <= '0;
         err    <= 1'b0;
      end else begin
         phase  <= phase_nxt;
         pos    <= pos_nxt;
         step   <= step_nxt;
         mask   <= mask_nxt;
         cap_rd <= cap_rd_nxt;
         cap_rs <= cap_rs_nxt;
         err    <= err_nxt;
      end
   end

   // Next state: capture while idle, otherwise walk the set bits of mask
   always_comb begin
      phase_nxt   = phase;
      pos_nxt     = pos;
      step_nxt    = step;
      mask_nxt    = mask;
      cap_rd_nxt  = cap_rd;
      cap_rs_nxt  = cap_rs;
      err_nxt     = err;
      phase_after = phase;
      pos_after   = pos;
      mask_after  = mask;
      nb_after    = '0;
      resolve     = 1'b0;
      last_op     = 1'b0;

      if (!bus.ucode_flag) begin
         cap_rd_nxt = bus.mul_imm_rd;
         cap_rs_nxt = bus.mul_imm_rs;
         mask_nxt   = bus.mul_imm_imm;
         pos_nxt    = '0;
         step_nxt   = '0;
         phase_nxt  = P_COPY;
      end else begin
         if (bus.ghost_PC != step[REG_W-1:0]) err_nxt = 1'b1;

         if (!op_valid) begin
            err_nxt = 1'b1;
            last_op = 1'b1;
         end else begin
            case (phase)
               P_COPY: begin
                  if (is_acc) resolve = 1'b1;
                  else        phase_after = P_CLEAR;
               end
               P_CLEAR: resolve = 1'b1;
               P_SHIFT: begin
                  pos_after   = nb_cur[REG_W-1:0];
                  phase_after = P_ADD;
               end
               P_ADD: begin
                  mask_after[nb_cur[REG_W-1:0]] = 1'b0;
                  resolve = 1'b1;
               end
               P_FLAGS: last_op = 1'b1;
               default: last_op = 1'b1;
            endcase

            if (resolve) begin
               nb_after = lowest_set(mask_after);
               if (nb_after[4])
                  phase_after = (nb_after[REG_W-1:0] == pos_after) ? P_ADD : P_SHIFT;
               else if (is_s)
                  phase_after = P_FLAGS;
               else
                  last_op = 1'b1;
            end

            phase_nxt = phase_after;
            pos_nxt   = pos_after;
            mask_nxt  = mask_after;
            step_nxt  = step + STEP_W'(1);
         end

         if (last_op) begin
            phase_nxt = P_COPY;
            pos_nxt   = '0;
            step_nxt  = '0;
         end
      end
   end

   // Outputs: micro-op for the current phase, NOP when idle or on a bad opcode
   always_comb begin
      instr = NOP_WORD;
      done  = 1'b0;
      if (bus.ucode_flag) begin
         if (!op_valid) begin
            done = 1'b1;
         end else begin
            done = last_op;
            case (phase)
               P_COPY:  instr = uop(OP_MOV,  SCRATCH, cap_rs,  16'd0);
               P_CLEAR: instr = uop(OP_MOVI, cap_rd,  4'd0,    16'd0);
               P_SHIFT: instr = uop(OP_LSL,  SCRATCH, SCRATCH,
                                    {12'd0, 4'(nb_cur[REG_W-1:0] - pos)});
               P_ADD:   instr = uop(OP_ADD,  cap_rd,  cap_rd,  {12'd0, SCRATCH});
               P_FLAGS: instr = uop(OP_CMPI, cap_rd,  cap_rd,  16'd0);
               default: instr = NOP_WORD;
            endcase
         end
      end
   end

   assign bus.ghost_instruction = instr;
   assign bus.ucode_done        = done;
   assign bus.seq_err           = err;
endmodule

// File: tb/tb_mul_ucode_seq.sv
// Randomized scoreboard bench for mul_ucode_seq against a bit-walking reference model.
module tb_mul_ucode_seq;
   localparam logic [6:0]  OP_NOP  = 7'b1100100;
   localparam logic [6:0]  OP_MOV  = 7'b0000001;
   localparam logic [6:0]  OP_MOVI = 7'b0000010;
   localparam logic [6:0]  OP_ADD  = 7'b0000100;
   localparam logic [6:0]  OP_LSL  = 7'b0000110;
   localparam logic [6:0]  OP_CMPI = 7'b0001010;
   localparam logic [6:0]  MULI    = 7'b0010000;
   localparam logic [6:0]  MULI_S  = 7'b0011000;
   localparam logic [6:0]  MLAI    = 7'b0110000;
   localparam logic [6:0]  MLAI_S  = 7'b0111000;
   localparam logic [31:0] NOP_W   = {OP_NOP, 25'd0};

   typedef struct packed {
      logic [31:0] instr;
      logic        done;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;
   logic exp_err = 1'b0;
   exp_t sb[$];
   exp_t model_q[$];

   mul_ucode_seq_if bus ();

   mul_ucode_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   function automatic logic [31:0] word(input logic [6:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [15:0] imm);
      return {op, rd, rs, 1'b0, imm};
   endfunction

   // Reference: copy, optional clear, then a shift+add per set bit, optional compare
   task automatic build_model(input logic [6:0] opc, input logic [3:0] rd,
                              input logic [3:0] rs, input logic [15:0] imm);
      int   pos;
      exp_t e;
      model_q.delete();
      if (!(opc == MULI || opc == MULI_S || opc == MLAI || opc == MLAI_S)) begin
         model_q.push_back('{instr: NOP_W, done: 1'b1});
         return;
      end
      model_q.push_back('{instr: word(OP_MOV, 4'd15, rs, 16'd0), done: 1'b0});
      if (opc == MULI || opc == MULI_S)
         model_q.push_back('{instr: word(OP_MOVI, rd, 4'd0, 16'd0), done: 1'b0});
      pos = 0;
      for (int b = 0; b < 16; b++) begin
         if (imm[b]) begin
            if (b != pos)
               model_q.push_back('{instr: word(OP_LSL, 4'd15, 4'd15, 16'(b - pos)), done: 1'b0});
            pos = b;
            model_q.push_back('{instr: word(OP_ADD, rd, rd, 16'd15), done: 1'b0});
         end
      end
      if (opc == MULI_S || opc == MLAI_S)
         model_q.push_back('{instr: word(OP_CMPI, rd, rd, 16'd0), done: 1'b0});
      e = model_q.pop_back();
      e.done = 1'b1;
      model_q.push_back(e);
   endtask

   // Present one instruction; stop_at>0 truncates (abort), bad_step corrupts ghost_PC once,
   // rst_at_stop pulses reset during the last presented op.
   task automatic run_seq(input logic [6:0] opc, input logic [3:0] rd, input logic [3:0] rs,
                          input logic [15:0] imm, input int stop_at, input int bad_step,
                          input bit rst_at_stop);
      int cnt;
      build_model(opc, rd, rs, imm);
      cnt = model_q.size();
      if (stop_at > 0 && stop_at < cnt) cnt = stop_at;
      if (opc != MULI && opc != MULI_S && opc != MLAI && opc != MLAI_S) exp_err = 1'b1;
      for (int i = 0; i < cnt; i++) sb.push_back(model_q[i]);

      bus.ucode_flag  = 1'b0;
      bus.mul_opcode  = opc;
      bus.mul_imm_rd  = rd;
      bus.mul_imm_rs  = rs;
      bus.mul_imm_imm = imm;
      bus.ghost_PC    = 4'd0;
      @(posedge clk); #1;
      for (int i = 0; i < cnt; i++) begin
         bus.ucode_flag  = 1'b1;
         bus.ghost_PC    = (i == bad_step) ? 4'(i + 1) : 4'(i);
         bus.mul_imm_rd  = 4'($urandom);
         bus.mul_imm_rs  = 4'($urandom);
         bus.mul_imm_imm = 16'($urandom);
         if (i == bad_step) exp_err = 1'b1;
         if (rst_at_stop && i == cnt - 1) rst = 1'b1;
         @(posedge clk); #1;
      end
      bus.ucode_flag = 1'b0;
      bus.ghost_PC   = 4'd0;
      if (rst) begin
         rst = 1'b0;
         exp_err = 1'b0;
      end
      check("seq_err", 32'(bus.seq_err), 32'(exp_err));
   endtask

   // Monitor: every presented op is popped from the scoreboard; idle must be NOP
   always @(negedge clk) begin
      exp_t e;
      if (bus.ucode_flag) begin
         if (sb.size() == 0) begin
            check("unexpected_op", bus.ghost_instruction, NOP_W ^ 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("uop", bus.ghost_instruction, e.instr);
            check("ucode_done", 32'(bus.ucode_done), 32'(e.done));
         end
      end else begin
         check("idle_uop", bus.ghost_instruction, NOP_W);
         check("idle_done", 32'(bus.ucode_done), 32'd0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [6:0] opcs [4];
      opcs[0] = MULI; opcs[1] = MULI_S; opcs[2] = MLAI; opcs[3] = MLAI_S;
      bus.ucode_flag  = 1'b0;
      bus.mul_opcode  = 7'd0;
      bus.mul_imm_rd  = 4'd0;
      bus.mul_imm_rs  = 4'd0;
      bus.mul_imm_imm = 16'd0;
      bus.ghost_PC    = 4'd0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_seq_err", 32'(bus.seq_err), 32'd0);
      rst = 1'b0;

      run_seq(MULI,   4'd3, 4'd5, 16'h0005, 0, -1, 1'b0);
      run_seq(MLAI_S, 4'd2, 4'd2, 16'h8000, 0, -1, 1'b0);
      run_seq(MULI_S, 4'd1, 4'd4, 16'hFFFF, 0, -1, 1'b0);
      run_seq(MLAI,   4'd6, 4'd7, 16'h0000, 0, -1, 1'b0);
      run_seq(MULI,   4'd6, 4'd7, 16'h0000, 0, -1, 1'b0);
      // abort by dropping ucode_flag early: no error, next instruction clean
      run_seq(MULI_S, 4'd9, 4'd8, 16'hFFFF, 5, -1, 1'b0);
      run_seq(MULI,   4'd3, 4'd5, 16'h0005, 0, -1, 1'b0);

      for (int k = 0; k < 20; k++) begin
         logic [15:0] imm;
         imm = 16'($urandom);
         if (k % 3 == 0) imm = imm & 16'($urandom) & 16'($urandom);
         run_seq(opcs[$urandom_range(0, 3)], 4'($urandom), 4'($urandom), imm, 0, -1, 1'b0);
      end

      run_seq(MULI_S, 4'd1, 4'd4, 16'hFFFF, 0, 20, 1'b0);
      run_seq(MLAI,   4'd2, 4'd3, 16'h00A5, 0, -1, 1'b0);
      run_seq(MULI,   4'd3, 4'd5, 16'h00FF, 4, -1, 1'b1);
      run_seq(MULI,   4'd3, 4'd5, 16'h0005, 0, -1, 1'b0);
      run_seq(7'b0000011, 4'd1, 4'd2, 16'h1234, 0, -1, 1'b0);

      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_err = 1'b0;
      check("rst_clears_err", 32'(bus.seq_err), 32'(exp_err));

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
